// File: rtl/product_accumulator.sv
// product_accumulator
//
// Sums COUNT consecutive unsigned products from the 4x4 binary_multiplier
// into one result and hands that result to the next stage. Input and output
// each use a valid/ready handshake. The block alternates between two states:
// ACCUM accepts products, and HOLD presents the finished sum until the
// downstream stage takes it.
//
// Parameters:
//   PROD_W  width of an incoming product (default 8)
//   ACC_W   accumulator / out_sum width, >= PROD_W (default 12)
//   COUNT   products summed per result, >= 1 (default 4)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   clear        synchronous abort; discards partial or held result
//   in_valid     in_product is valid
//   in_ready     block accepts a product (high only in ACCUM)
//   in_product   unsigned product, PROD_W bits
//   out_valid    out_sum / out_overflow valid (high only in HOLD)
//   out_ready    downstream accepts the result
//   out_sum      accumulated sum, ACC_W bits (registered)
//   out_overflow sticky carry-out of the accumulator for this result
//
// Build option:
//   PRODUCT_ACC_SAT_EN  when defined, the accumulator clamps to all-ones on
//                       overflow. When undefined, it wraps modulo 2^ACC_W.
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int EXT_W = ACC_W + 1 - PROD_W;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_add;

    // One extra bit so the carry-out can be observed directly.
    always_comb begin
        sum_ext = {1'b0, acc_q} + {{EXT_W{1'b0}}, in_product};
`ifdef PRODUCT_ACC_SAT_EN
        // Once clamped, any further non-zero product carries again, so the
        // accumulator stays at all-ones for the rest of the group.
        acc_add = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
        acc_add = sum_ext[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (state_q == ACCUM) begin
            if (in_valid) begin
                acc_d = acc_add;
                ovf_d = ovf_q | sum_ext[ACC_W];
                if (cnt_q == CNT_W'(COUNT - 1)) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs depend on registered state only.
    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign out_sum      = acc_q;
    assign out_overflow = ovf_q;

endmodule
